// File: rtl/quadencoder_gen.sv
// Quadrature encoder signal generator: signed velocity -> registered A/B/Z plus position count.
// Optional sticky overspeed flag is enabled by defining QUADENCODER_GEN_OVERSPEED_EN.
module quadencoder_gen #(
  parameter int BITS          = 32,
  parameter int RATE_BITS     = 32,
  parameter int PPR_COUNTS    = 4000,
  parameter int MIN_EDGE_CLKS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [RATE_BITS-1:0] velocity,
  input  logic                 load,
  input  logic [BITS-1:0]      load_value,
  input  logic                 overspeed_clr,
  output logic                 a,
  output logic                 b,
  output logic                 z,
  output logic [BITS-1:0]      position,
  output logic                 overspeed
);

  localparam int TW = $clog2(MIN_EDGE_CLKS + 1);
  localparam int RW = $clog2(PPR_COUNTS);
  localparam logic [TW-1:0]        TIMER_MAX = TW'(MIN_EDGE_CLKS);
  localparam logic [RW-1:0]        REV_LAST  = RW'(PPR_COUNTS - 1);
  localparam logic [RATE_BITS-1:0] MOST_NEG  = {1'b1, {(RATE_BITS-1){1'b0}}};
  localparam logic [RATE_BITS-1:0] MAX_POS   = {1'b0, {(RATE_BITS-1){1'b1}}};

  logic [RATE_BITS-1:0] acc;
  logic [RATE_BITS-1:0] mag;
  logic [RATE_BITS:0]   sum;
  logic [TW-1:0]        edge_timer;
  logic [RW-1:0]        rev_count;
  logic                 pending;
  logic                 pending_dir;
  logic                 pending_next;
  logic                 pending_dir_next;
  logic                 request;
  logic                 dir;
  logic                 ready;
  logic                 step;
  logic                 step_dir;
  logic                 drop;

  // Magnitude of the command; the most negative value has no positive twin, so it saturates.
  always_comb begin
    if (velocity == MOST_NEG)    mag = MAX_POS;
    else if (velocity[RATE_BITS-1]) mag = -velocity;
    else                         mag = velocity;
  end

  assign sum     = {1'b0, acc} + {1'b0, mag};
  assign request = enable & sum[RATE_BITS];
  assign dir     = velocity[RATE_BITS-1];
  assign ready   = (edge_timer == TIMER_MAX);

  // A waiting step goes first; a fresh request then takes its place in the one-deep queue.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    step             = 1'b0;
    step_dir         = dir;
    pending_next     = pending;
    pending_dir_next = pending_dir;
    drop             = 1'b0;
    if (!enable || load) begin
      pending_next = 1'b0;
    end else if (ready && pending) begin
      step             = 1'b1;
      step_dir         = pending_dir;
      pending_next     = request;
      pending_dir_next = dir;
    end else if (ready && request) begin
      step = 1'b1;
    end else if (request && !pending) begin
      pending_next     = 1'b1;
      pending_dir_next = dir;
    end else if (request) begin
      drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      a           <= 1'b0;
      b           <= 1'b0;
      z           <= 1'b0;
      position    <= '0;
      acc         <= '0;
      rev_count   <= '0;
      pending     <= 1'b0;
      pending_dir <= 1'b0;
      edge_timer  <= TIMER_MAX;
    end else begin
      z           <= enable & (rev_count == '0);
      pending     <= pending_next;
      pending_dir <= pending_dir_next;
      if (step)       edge_timer <= TW'(1);
      else if (!ready) edge_timer <= edge_timer + TW'(1);
      if (load) begin
        position  <= load_value;
        rev_count <= '0;
        acc       <= '0;
      end else begin
        if (enable) acc <= sum[RATE_BITS-1:0];
        if (step) begin
          // AB walks 00->10->11->01 forward; the reverse walk is the mirror rotation.
          if (step_dir) begin
            a         <= b;
            b         <= ~a;
            position  <= position - BITS'(1);
            rev_count <= (rev_count == '0) ? REV_LAST : rev_count - RW'(1);
          end else begin
            a         <= ~b;
            b         <= a;
            position  <= position + BITS'(1);
            rev_count <= (rev_count == REV_LAST) ? '0 : rev_count + RW'(1);
          end
        end
      end
    end
  end

`ifdef QUADENCODER_GEN_OVERSPEED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overspeed <= 1'b0;
    else if (overspeed_clr) overspeed <= 1'b0;
    else if (drop)          overspeed <= 1'b1;
  end
`else
  logic unused_ovs;
  assign unused_ovs = overspeed_clr ^ drop;
  assign overspeed  = 1'b0;
`endif

endmodule

// File: tb/tb_quadencoder_gen.sv
// Self-checking bench for quadencoder_gen: cycle model built from counts, phase index and
// modular arithmetic, compared every cycle, plus literal expectations for the key scenarios.
module tb_quadencoder_gen;

  localparam int BITS = 16;
  localparam int RB   = 32;
  localparam int PPR  = 8;
  localparam int MINE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [RB-1:0]   velocity = '0;
  logic            load = 1'b0;
  logic [BITS-1:0] load_value = '0;
  logic            overspeed_clr = 1'b0;
  logic            a, b, z, overspeed;
  logic [BITS-1:0] position;

  quadencoder_gen #(
    .BITS(BITS), .RATE_BITS(RB), .PPR_COUNTS(PPR), .MIN_EDGE_CLKS(MINE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .velocity(velocity), .load(load),
    .load_value(load_value), .overspeed_clr(overspeed_clr), .a(a), .b(b), .z(z),
    .position(position), .overspeed(overspeed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference state: integer position, phase index 0..3 (AB = 00,10,11,01), cycles since last edge.
  longint m_acc;
  int     m_pos, m_phase, m_rev, m_since;
  bit     m_pend, m_pend_rev, m_z, m_ovs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit phase_a(input int ph);
    return (ph == 1) || (ph == 2);
  endfunction

  function automatic bit phase_b(input int ph);
    return (ph == 2) || (ph == 3);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_pos = 0; m_phase = 0; m_rev = 0; m_since = MINE;
    m_pend = 0; m_pend_rev = 0; m_z = 0; m_ovs = 0;
  endtask

  task automatic model_update();
    int     vs;
    longint mag;
    bit     req, vrev, fire, frev, drop, zn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vs = int'($signed(velocity));
    if (vs == -2147483647 - 1) mag = 64'd2147483647;
    else if (vs < 0)           mag = -longint'(vs);
    else                       mag = longint'(vs);
    vrev = (vs < 0);
    req = 0; fire = 0; frev = 0; drop = 0;
    zn = enable && (m_rev == 0);
    if (load) begin
      m_pos = int'($signed(load_value)); m_rev = 0; m_acc = 0; m_pend = 0;
    end else if (!enable) begin
      m_pend = 0;
    end else begin
      m_acc = m_acc + mag;
      if (m_acc >= 64'h1_0000_0000) begin
        req = 1;
        m_acc = m_acc - 64'h1_0000_0000;
      end
      if (m_since >= MINE && m_pend) begin
        fire = 1; frev = m_pend_rev; m_pend = req; m_pend_rev = vrev;
      end else if (m_since >= MINE && req) begin
        fire = 1; frev = vrev;
      end else if (req && !m_pend) begin
        m_pend = 1; m_pend_rev = vrev;
      end else if (req) begin
        drop = 1;
      end
    end
    if (fire) begin
      if (frev) begin
        m_pos--; m_phase = (m_phase + 3) % 4; m_rev = (m_rev + PPR - 1) % PPR;
      end else begin
        m_pos++; m_phase = (m_phase + 1) % 4; m_rev = (m_rev + 1) % PPR;
      end
      m_since = 1;
    end else if (m_since < MINE) begin
      m_since++;
    end
    m_z = zn;
`ifdef QUADENCODER_GEN_OVERSPEED_EN
    if (overspeed_clr) m_ovs = 0;
    else if (drop)     m_ovs = 1;
`endif
  endtask

  // One clock: model advances on the edge, inputs change again at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("a", a, phase_a(m_phase));
      check("b", b, phase_b(m_phase));
      check("z", z, m_z);
      check("position", position, m_pos[BITS-1:0]);
      check("overspeed", overspeed, m_ovs);
    end
  end

  logic            sav_a, sav_b;
  logic [BITS-1:0] sav_pos;

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    check("reset_position", position, 16'h0000);
    check("reset_ab", {a, b}, 2'b00);
    check("reset_z", z, 1'b0);
    rst_n = 1'b1;

    // Forward at a quarter count per clock: one step every 4 clocks.
    enable = 1'b1; velocity = 32'h4000_0000;
    repeat (400) tick();
    check("fwd_position", position, 16'd100);
    check("fwd_model_pin", m_pos, 100);
    check("fwd_ab", {a, b}, 2'b00);

    // Asynchronous reset in motion clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_position", position, 16'h0000);
    check("async_abz", {a, b, z}, 3'b000);
    tick();
    rst_n = 1'b1;

    // Reverse from zero: position goes negative, B leads A.
    velocity = -32'sh4000_0000;
    repeat (3) tick();
    tick();
    check("rev_first_ab", {a, b}, 2'b01);
    repeat (396) tick();
    check("rev_position", position, 16'hFF9C);
    check("rev_model_pin", m_pos, -100);

    // Mid-run load: position taken, a/b held, z raised on the following clock.
    velocity = 32'h4000_0000;
    repeat (6) tick();
    sav_a = a; sav_b = b;
    load = 1'b1; load_value = 16'd1000;
    tick();
    load = 1'b0;
    check("load_position", position, 16'd1000);
    check("load_ab_held", {a, b}, {sav_a, sav_b});
    tick();
    check("load_z", z, 1'b1);
    repeat (64) tick();

    // Position wraps two's complement with no flag.
    load = 1'b1; load_value = 16'h7FFF;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("wrap_position", position, 16'h8000);

    // Most negative command saturates to the largest magnitude, moving in reverse.
    velocity = 32'h8000_0000;
    repeat (40) tick();

    // Requests faster than the edge spacing: drops happen and the sticky flag shows them.
    velocity = 32'h6000_0000;
    repeat (64) tick();
`ifdef QUADENCODER_GEN_OVERSPEED_EN
    check("overspeed_set", overspeed, 1'b1);
`else
    check("overspeed_off", overspeed, 1'b0);
`endif
    velocity = '0;
    overspeed_clr = 1'b1;
    tick();
    overspeed_clr = 1'b0;
    check("overspeed_clr", overspeed, 1'b0);

    // Zero velocity keeps everything static.
    repeat (10) tick();
    sav_pos = position; sav_a = a; sav_b = b;
    repeat (20) tick();
    check("static_position", position, sav_pos);
    check("static_ab", {a, b}, {sav_a, sav_b});

    // Freeze: z forced low.
    velocity = 32'h4000_0000;
    enable = 1'b0;
    repeat (3) tick();
    check("freeze_z", z, 1'b0);
    enable = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) begin
        case ($urandom_range(0, 6))
          0: velocity = $urandom();
          1: velocity = 32'h4000_0000;
          2: velocity = -32'sh4000_0000;
          3: velocity = 32'h8000_0000;
          4: velocity = 32'h6000_0000;
          5: velocity = 32'(-int'($urandom_range(0, 32'h3000_0000)));
          default: velocity = '0;
        endcase
      end
      enable        = ($urandom_range(0, 15) != 0);
      load          = ($urandom_range(0, 63) == 0);
      load_value    = 16'($urandom());
      overspeed_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    load = 1'b0;
    overspeed_clr = 1'b0;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
